uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Serial receive front end for the CPU's memory-mapped UART. It sits directly upstream of the datapath's UART load path.
- Deserialises 8N1 frames from the serial input pin and buffers the received bytes in a small FIFO.
- Presents the head byte on DataOut/DataOutValid. The datapath pops a byte by asserting DataOutReady (its UART read enable).
- Also reports sticky framing and overrun errors for a status load.

Parameters:
CLOCK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, serial bit rate; SymbolEdge = CLOCK_FREQ/BAUD_RATE (integer division), SampleTime = SymbolEdge/2
FIFO_DEPTH, 4, byte entries; must be a power of two and at least 2

Ports:
CLK  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
SIn  input  1  serial line, idles high, asynchronous to CLK
DataOut  output  8  FIFO head byte; 8'h00 when the FIFO is empty
DataOutValid  output  1  FIFO not empty
DataOutReady  input  1  consumer pop request; a pop occurs on a rising edge where DataOutValid && DataOutReady
FramingError  output  1  sticky: a stop bit was sampled low
Overrun  output  1  sticky: a good byte was dropped because the FIFO was full
ErrClear  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset (asynchronous assert): FSM=IDLE, bit counter=0, clock counter=0, FIFO empty (rd/wr pointers and count = 0), DataOutValid=0, DataOut=0, FramingError=0, Overrun=0, both synchroniser flops=1.
- Input sync: SIn passes through a 2-flop synchroniser (rx_s). The previous rx_s value is held for edge detection. Only rx_s is used internally.
- Clock counter: clears on every FSM state change and otherwise counts up by 1 per cycle. Its width is clog2(SymbolEdge)+1.
- IDLE: go to START on a falling edge of rx_s (previous=1, current=0). A line held low never retriggers.
- START: when counter == SampleTime-1, sample rx_s.
  - rx_s=1: false start; go to IDLE with no flags set.
  - rx_s=0: go to DATA and set bit index to 0.
- DATA: when counter == SymbolEdge-1, shift rx_s into the shift register LSB-first, increment the bit index, and restart the counter. After the 8th sample, go to STOP.
- STOP: when counter == SymbolEdge-1, sample rx_s and go to IDLE.
  - rx_s=1 and the FIFO can accept: push the shift register.
  - rx_s=1 and the FIFO is full with no pop this cycle: drop the byte and set Overrun.
  - rx_s=0: drop the byte and set FramingError.
- Latency: a pushed byte appears at DataOut with DataOutValid=1 on the cycle after the stop-sample edge, about 9.5 bit times after the start edge.
- FIFO:
  - Circular buffer with wrap-around pointers (modulo FIFO_DEPTH).
  - DataOut = mem[rd_ptr] when count != 0, else 0. DataOut is combinational from registered state.
  - DataOutValid = (count != 0).
- Pop: DataOutValid && DataOutReady; rd_ptr advances and count decrements. DataOutReady while empty is ignored with no state change.
- Simultaneous push and pop:
  - Always allowed, including when full; count is unchanged and both pointers advance.
  - When count==1, the popped byte is the old head and the new byte becomes the head the next cycle.
- Count never exceeds FIFO_DEPTH and never underflows.
- Sticky flags: a set event and ErrClear in the same cycle resolve as set wins. ErrClear otherwise clears both flags the next cycle. Flags do not affect FIFO contents.
- Reset asserted mid-frame: the partial frame is discarded, the FIFO is emptied, and no flags are set. Reception resumes only on a new falling edge after reset deasserts.
- Data timing is not reset by receive activity. The FSM operates independently of FIFO pops.

Test Plan (CLOCK_FREQ=160, BAUD_RATE=10 → SymbolEdge=16, SampleTime=8; FIFO_DEPTH=4):
1. Single frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), DataOutReady=0 → DataOutValid rises 1 cycle after the stop sample; DataOut=8'hA5; both flags stay 0. Then pulse DataOutReady for 1 cycle → DataOutValid=0 and DataOut=8'h00 next cycle.
2. Glitch: SIn low for 4 cycles, then high → FSM returns to IDLE, DataOutValid stays 0, no flags set. A following valid frame 0x3C is received correctly.
3. Frame 0x55 with stop bit driven 0 → FramingError=1, DataOutValid=0. Pulse ErrClear → FramingError=0.
4. Five frames 0x01–0x05 back-to-back with no pops → 4 entries, Overrun=1. Pops return 0x01, 0x02, 0x03, 0x04, then DataOutValid=0.
5. FIFO full (0x10–0x13); assert DataOutReady on exactly the push cycle of 0x14 → no Overrun. Pops return 0x11, 0x12, 0x13, 0x14 (pointer wrap verified).
6. Assert reset asynchronously (off clock edge) mid-DATA of a frame with 2 bytes queued → outputs immediately become 0 (DataOutValid=0, DataOut=0). After release, a frame 0xE7 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream handshake and sticky status between the UART receiver and its consumer.
interface uart_rx_fifo_if;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;
  logic       FramingError;
  logic       Overrun;
  logic       ErrClear;

  // Receiver side: produces bytes and status, accepts pops and clears.
  modport master (
    output DataOut,
    output DataOutValid,
    output FramingError,
    output Overrun,
    input  DataOutReady,
    input  ErrClear
  );

  // Consumer side: reads bytes and status, issues pops and clears.
  modport slave (
    input  DataOut,
    input  DataOutValid,
    input  FramingError,
    input  Overrun,
    output DataOutReady,
    output ErrClear
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a small circular byte FIFO, with sticky framing/overrun flags.
module uart_rx_fifo #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             CLK,
  input logic             reset,
  input logic             SIn,
  uart_rx_fifo_if.master  bus
);

  localparam int unsigned SymbolEdge = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned SampleTime = SymbolEdge / 2;
  localparam int unsigned CntW       = $clog2(SymbolEdge) + 1;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW     = PtrW + 1;

  localparam logic [CntW-1:0]   SymbolLast = CntW'(SymbolEdge - 1);
  localparam logic [CntW-1:0]   SampleLast = CntW'(SampleTime - 1);
  localparam logic [CountW-1:0] FullCount  = CountW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic            r_rx_meta;
  logic            r_rx_s;
  logic            r_rx_prev;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW-1:0]   r_wr_ptr;
  logic [CountW-1:0] r_count;

  logic r_framing_err;
  logic r_overrun;

  logic w_stop_sample;
  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_ovr_set;
  logic w_fe_set;

  // Two-flop synchroniser on the serial line plus a delayed copy for falling-edge detection.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= SIn;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  // Push/pop/flag-set decisions; a full FIFO still accepts a byte when a pop frees a slot.
  always_comb begin
    w_stop_sample = (r_state == StStop) && (r_cnt == SymbolLast);
    w_pop         = (r_count != '0) && bus.DataOutReady;
    w_full        = (r_count == FullCount);
    w_push        = w_stop_sample && r_rx_s && (!w_full || w_pop);
    w_ovr_set     = w_stop_sample && r_rx_s && w_full && !w_pop;
    w_fe_set      = w_stop_sample && !r_rx_s;
  end

  // Receive FSM: start detect, mid-bit start check, LSB-first data shift, stop sample.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
      unique case (r_state)
        StIdle: begin
          if (r_rx_prev && !r_rx_s) begin
            r_state <= StStart;
            r_cnt   <= '0;
          end
        end
        StStart: begin
          if (r_cnt == SampleLast) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= StIdle;
            end else begin
              r_state   <= StData;
              r_bit_idx <= '0;
            end
          end
        end
        StData: begin
          if (r_cnt == SymbolLast) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= StStop;
            end
          end
        end
        StStop: begin
          if (r_cnt == SymbolLast) begin
            r_cnt   <= '0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // FIFO storage; contents are don't-care while not counted, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CountW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CountW'(1);
      end
    end
  end

  // Sticky error flags; a set event in the same cycle as ErrClear keeps the flag set.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_framing_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_fe_set) begin
        r_framing_err <= 1'b1;
      end else if (bus.ErrClear) begin
        r_framing_err <= 1'b0;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (bus.ErrClear) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.DataOut      = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
  assign bus.DataOutValid = (r_count != '0);
  assign bus.FramingError = r_framing_err;
  assign bus.Overrun      = r_overrun;

endmodule
